// File: rtl/csr_irq.sv
// Machine-mode CSR file and interrupt controller for tinyrv: edge/level external lines,
// timer interrupt, fixed-priority trap cause, MIE/MPIE stacking and direct/vectored mtvec.
module csr_irq #(
    parameter int unsigned        NUM_EXT   = 4,
    parameter logic [NUM_EXT-1:0] EDGE_MASK = '1,
    parameter int unsigned        PC_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               intr_timer,
    input  logic [NUM_EXT-1:0] intr_ext,
    input  logic [2:0]         exceptions,
    input  logic               enter_isr,
    input  logic               mret,
    output logic               interrupt_pending,
    input  logic [11:0]        addr,
    input  logic [31:0]        data_in,
    input  logic               write_en,
    output logic [31:0]        data_out,
    input  logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    isr_return,
    output logic [PC_W-1:0]    isr_target
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;

    logic               mstatus_mie_q, mstatus_mie_d;
    logic               mstatus_mpie_q, mstatus_mpie_d;
    logic               mtie_q, mtie_d;
    logic [NUM_EXT-1:0] meie_q, meie_d;
    logic               mtip_q, mtip_d;
    logic [NUM_EXT-1:0] meip_q, meip_d;
    logic [NUM_EXT-1:0] ext_prev_q, ext_prev_d;
    logic               armed_q, armed_d;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mscratch_q, mscratch_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;

    logic [NUM_EXT-1:0] pend_ext;
    logic               pend_timer;
    logic               ext_hit;
    logic [3:0]         ext_sel;
    logic [31:0]        trap_cause;
    logic [NUM_EXT-1:0] edge_set;
    logic [NUM_EXT-1:0] trap_clr;
    logic [NUM_EXT-1:0] sw_clr;
    logic [PC_W-3:0]    vec_sum;
    logic [31:0]        mie_rd;
    logic [31:0]        mip_rd;

    assign pend_ext          = meie_q & meip_q;
    assign pend_timer        = mtie_q & mtip_q;
    assign interrupt_pending = mstatus_mie_q & (pend_timer | (|pend_ext));

    // Descending scan so the lowest pending line index is the one left selected.
    always_comb begin
        ext_hit = 1'b0;
        ext_sel = '0;
        for (int i = int'(NUM_EXT) - 1; i >= 0; i--) begin
            if (pend_ext[i]) begin
                ext_hit = 1'b1;
                ext_sel = 4'(i);
            end
        end
    end

    always_comb begin
        if (ext_hit) begin
            trap_cause = {1'b1, 26'd0, 1'b1, ext_sel};
        end else if (pend_timer) begin
            trap_cause = 32'h8000_0007;
        end else if (exceptions[1]) begin
            trap_cause = 32'd2;
        end else if (exceptions[0]) begin
            trap_cause = 32'd0;
        end else if (exceptions[2]) begin
            trap_cause = 32'd5;
        end else begin
            trap_cause = 32'd11;
        end
    end

    assign vec_sum    = mtvec_q[PC_W-1:2] + (PC_W-2)'(trap_cause[4:0]);
    assign isr_target = (mtvec_q[1:0] == 2'b01 && trap_cause[31]) ? {vec_sum, 2'b00}
                                                                   : {mtvec_q[PC_W-1:2], 2'b00};
    assign isr_return = mepc_q[PC_W-1:0];

    // The first cycle after reset only captures history, so a line held through reset is not an edge.
    assign edge_set = intr_ext & ~ext_prev_q & {NUM_EXT{armed_q}} & EDGE_MASK;
    assign sw_clr   = (write_en && addr == ADDR_MIP) ? ~data_in[16 +: NUM_EXT] : '0;

    always_comb begin
        trap_clr = '0;
        for (int i = 0; i < int'(NUM_EXT); i++) begin
            trap_clr[i] = enter_isr && ext_hit && (ext_sel == 4'(i));
        end
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mtie_d         = mtie_q;
        meie_d         = meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtip_d         = intr_timer;
        ext_prev_d     = intr_ext;
        armed_d        = 1'b1;
        meip_d         = (EDGE_MASK & ((meip_q & ~trap_clr & ~sw_clr) | edge_set))
                       | (~EDGE_MASK & intr_ext);

        if (write_en) begin
            case (addr)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = data_in[3];
                    mstatus_mpie_d = data_in[7];
                end
                ADDR_MIE: begin
                    mtie_d = data_in[7];
                    meie_d = data_in[16 +: NUM_EXT];
                end
                ADDR_MTVEC:    mtvec_d    = data_in;
                ADDR_MSCRATCH: mscratch_d = data_in;
                ADDR_MEPC:     mepc_d     = data_in & ~32'h1;
                ADDR_MCAUSE:   mcause_d   = data_in;
                default:       ;
            endcase
        end

        // Trap bookkeeping is applied last so it overrides same-cycle software writes and mret.
        if (enter_isr) begin
            mepc_d         = 32'(pc) & ~32'h1;
            mcause_d       = trap_cause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mtie_q         <= 1'b0;
            meie_q         <= '0;
            mtip_q         <= 1'b0;
            meip_q         <= '0;
            ext_prev_q     <= '0;
            armed_q        <= 1'b0;
            mtvec_q        <= 32'h0000_0001;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mtie_q         <= mtie_d;
            meie_q         <= meie_d;
            mtip_q         <= mtip_d;
            meip_q         <= meip_d;
            ext_prev_q     <= ext_prev_d;
            armed_q        <= armed_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

    always_comb begin
        mie_rd              = '0;
        mie_rd[7]           = mtie_q;
        mie_rd[16 +: NUM_EXT] = meie_q;
        mip_rd              = '0;
        mip_rd[7]           = mtip_q;
        mip_rd[16 +: NUM_EXT] = meip_q;
    end

    always_comb begin
        case (addr)
            ADDR_MSTATUS:  data_out = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            ADDR_MIE:      data_out = mie_rd;
            ADDR_MTVEC:    data_out = mtvec_q;
            ADDR_MSCRATCH: data_out = mscratch_q;
            ADDR_MEPC:     data_out = mepc_q;
            ADDR_MCAUSE:   data_out = mcause_q;
            ADDR_MIP:      data_out = mip_rd;
            default:       data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_irq.sv
// Directed bench for csr_irq: dutA uses all-edge lines, dutB uses EDGE_MASK 4'b1110
// (line 0 level). Both share stimulus; each section checks the relevant instance.
`timescale 1ns/1ps
module tb_csr_irq;

    logic        clk;
    logic        reset;
    logic        intrTimer;
    logic [3:0]  intrExt;
    logic [2:0]  exceptions;
    logic        enterIsr;
    logic        mretIn;
    logic [11:0] addr;
    logic [31:0] dataIn;
    logic        writeEn;
    logic [15:0] pc;

    logic        irqPendA, irqPendB;
    logic [31:0] dataOutA, dataOutB;
    logic [15:0] isrReturnA, isrReturnB;
    logic [15:0] isrTargetA, isrTargetB;

    int compareCount = 0;
    int failCount    = 0;

    csr_irq #(.NUM_EXT(4), .EDGE_MASK(4'b1111), .PC_W(16)) dutA (
        .clk(clk), .reset(reset), .intr_timer(intrTimer), .intr_ext(intrExt),
        .exceptions(exceptions), .enter_isr(enterIsr), .mret(mretIn),
        .interrupt_pending(irqPendA), .addr(addr), .data_in(dataIn), .write_en(writeEn),
        .data_out(dataOutA), .pc(pc), .isr_return(isrReturnA), .isr_target(isrTargetA)
    );

    csr_irq #(.NUM_EXT(4), .EDGE_MASK(4'b1110), .PC_W(16)) dutB (
        .clk(clk), .reset(reset), .intr_timer(intrTimer), .intr_ext(intrExt),
        .exceptions(exceptions), .enter_isr(enterIsr), .mret(mretIn),
        .interrupt_pending(irqPendB), .addr(addr), .data_in(dataIn), .write_en(writeEn),
        .data_out(dataOutB), .pc(pc), .isr_return(isrReturnB), .isr_target(isrTargetB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One clock with the currently driven inputs; single-cycle strobes drop afterwards.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        enterIsr = 1'b0;
        mretIn   = 1'b0;
        writeEn  = 1'b0;
    endtask

    task automatic writeCsr(input logic [11:0] a, input logic [31:0] d);
        addr    = a;
        dataIn  = d;
        writeEn = 1'b1;
        applyStimulus();
    endtask

    task automatic readA(input logic [11:0] a, input logic [31:0] expected, input string tag);
        addr = a;
        #1;
        checkOutput(tag, dataOutA, expected);
    endtask

    task automatic readB(input logic [11:0] a, input logic [31:0] expected, input string tag);
        addr = a;
        #1;
        checkOutput(tag, dataOutB, expected);
    endtask

    initial begin
        reset      = 1'b1;
        intrTimer  = 1'b0;
        intrExt    = 4'b0000;
        exceptions = 3'b000;
        enterIsr   = 1'b0;
        mretIn     = 1'b0;
        addr       = 12'h000;
        dataIn     = 32'h0;
        writeEn    = 1'b0;
        pc         = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        #1;
        checkOutput("rst_irq_pending", {31'd0, irqPendA}, 32'h0);
        checkOutput("rst_isr_return", {16'd0, isrReturnA}, 32'h0);
        checkOutput("rst_isr_target", {16'd0, isrTargetA}, 32'h0);
        readA(12'h305, 32'h0000_0001, "rst_mtvec");
        readA(12'h300, 32'h0000_0000, "rst_mstatus");
        readA(12'h344, 32'h0000_0000, "rst_mip");

        // Basic CSR read/write behaviour
        writeCsr(12'h300, 32'hFFFF_FFFF);
        readA(12'h300, 32'h0000_0088, "mstatus_mask");
        writeCsr(12'h340, 32'hDEAD_BEEF);
        readA(12'h340, 32'hDEAD_BEEF, "mscratch_rw");
        writeCsr(12'h123, 32'hFFFF_FFFF);
        readA(12'h123, 32'h0000_0000, "unmapped_read");
        writeCsr(12'h341, 32'h0000_1235);
        readA(12'h341, 32'h0000_1234, "mepc_bit0");
        checkOutput("isr_return_mepc", {16'd0, isrReturnA}, 32'h0000_1234);
        writeCsr(12'h342, 32'h1234_5678);
        readA(12'h342, 32'h1234_5678, "mcause_rw");
        writeCsr(12'h304, 32'hFFFF_FFFF);
        readA(12'h304, 32'h000F_0080, "mie_mask");

        // Vectored external trap on line 2
        writeCsr(12'h305, 32'h0000_0101);
        readA(12'h305, 32'h0000_0101, "mtvec_rw");
        writeCsr(12'h304, 32'h0004_0000);
        intrExt = 4'b0100;
        #1;
        checkOutput("irq_not_yet", {31'd0, irqPendA}, 32'h0);
        applyStimulus();
        intrExt = 4'b0000;
        #1;
        checkOutput("irq_pending_line2", {31'd0, irqPendA}, 32'h1);
        checkOutput("vec_target_line2", {16'd0, isrTargetA}, 32'h0000_0148);
        readA(12'h344, 32'h0004_0000, "mip_line2");
        pc       = 16'h0234;
        enterIsr = 1'b1;
        #1;
        checkOutput("vec_target_trap_cycle", {16'd0, isrTargetA}, 32'h0000_0148);
        applyStimulus();
        readA(12'h341, 32'h0000_0234, "trap_mepc");
        checkOutput("trap_isr_return", {16'd0, isrReturnA}, 32'h0000_0234);
        readA(12'h342, 32'h8000_0012, "trap_mcause");
        readA(12'h300, 32'h0000_0080, "trap_mstatus");
        readA(12'h344, 32'h0000_0000, "trap_clears_edge");
        checkOutput("irq_after_trap", {31'd0, irqPendA}, 32'h0);

        // mret restore, then trap and mret together
        mretIn = 1'b1;
        applyStimulus();
        readA(12'h300, 32'h0000_0088, "mret_mstatus");
        enterIsr = 1'b1;
        mretIn   = 1'b1;
        pc       = 16'h0235;
        applyStimulus();
        readA(12'h300, 32'h0000_0080, "trap_beats_mret");
        readA(12'h342, 32'h0000_000B, "ecall_cause");
        readA(12'h341, 32'h0000_0234, "odd_pc_mepc");

        // Exceptions with no interrupt pending
        exceptions = 3'b011;
        enterIsr   = 1'b1;
        #1;
        checkOutput("exc_direct_target", {16'd0, isrTargetA}, 32'h0000_0100);
        applyStimulus();
        exceptions = 3'b000;
        readA(12'h342, 32'h0000_0002, "exc_illegal_first");
        exceptions = 3'b100;
        enterIsr   = 1'b1;
        pc         = 16'h0300;
        addr       = 12'h341;
        dataIn     = 32'h0000_5678;
        writeEn    = 1'b1;
        applyStimulus();
        exceptions = 3'b000;
        readA(12'h341, 32'h0000_0300, "trap_beats_mepc_write");
        readA(12'h342, 32'h0000_0005, "exc_load_fault");
        exceptions = 3'b101;
        enterIsr   = 1'b1;
        addr       = 12'h340;
        dataIn     = 32'hCAFE_F00D;
        writeEn    = 1'b1;
        applyStimulus();
        exceptions = 3'b000;
        readA(12'h340, 32'hCAFE_F00D, "mscratch_write_with_trap");
        readA(12'h342, 32'h0000_0000, "exc_misaligned_before_load");

        // Priority between external lines and timer
        writeCsr(12'h300, 32'h0000_0008);
        writeCsr(12'h304, 32'h0009_0080);
        intrExt   = 4'b1001;
        intrTimer = 1'b1;
        applyStimulus();
        intrExt = 4'b0000;
        #1;
        checkOutput("prio_irq_pending", {31'd0, irqPendA}, 32'h1);
        checkOutput("prio_line0_target", {16'd0, isrTargetA}, 32'h0000_0140);
        readA(12'h344, 32'h0009_0080, "prio_mip");
        writeCsr(12'h344, 32'hFFFE_FFFF);
        #1;
        checkOutput("prio_line3_target", {16'd0, isrTargetA}, 32'h0000_014C);
        readA(12'h344, 32'h0008_0080, "sw_clear_line0");
        writeCsr(12'h304, 32'h0000_0080);
        #1;
        checkOutput("prio_timer_target", {16'd0, isrTargetA}, 32'h0000_011C);
        enterIsr = 1'b1;
        applyStimulus();
        readA(12'h342, 32'h8000_0007, "timer_mcause");
        readA(12'h344, 32'h0008_0080, "timer_trap_keeps_line3");
        readA(12'h300, 32'h0000_0080, "timer_trap_mstatus");
        intrTimer = 1'b0;
        applyStimulus();

        // Edge vs level on dutB (line 0 level, line 1 edge)
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        writeCsr(12'h300, 32'h0000_0008);
        writeCsr(12'h304, 32'h0003_0000);
        intrExt = 4'b0011;
        applyStimulus();
        #1;
        checkOutput("lvl_irq_pending", {31'd0, irqPendB}, 32'h1);
        readB(12'h344, 32'h0003_0000, "lvl_mip_both");
        enterIsr = 1'b1;
        intrExt  = 4'b0000;
        applyStimulus();
        readB(12'h342, 32'h8000_0010, "lvl_mcause_line0");
        readB(12'h344, 32'h0002_0000, "lvl_line0_drops");
        applyStimulus();
        readB(12'h344, 32'h0002_0000, "edge_line1_sticky");
        writeCsr(12'h344, 32'h0000_0000);
        readB(12'h344, 32'h0000_0000, "edge_sw_clear");
        intrExt = 4'b0010;
        applyStimulus();
        intrExt = 4'b0000;
        applyStimulus();
        readB(12'h344, 32'h0002_0000, "edge_rearm");
        intrExt = 4'b0010;
        writeCsr(12'h344, 32'h0000_0000);
        readB(12'h344, 32'h0002_0000, "edge_set_beats_clear");
        writeCsr(12'h300, 32'h0000_0008);
        enterIsr = 1'b1;
        applyStimulus();
        readB(12'h342, 32'h8000_0011, "edge_mcause_line1");
        readB(12'h344, 32'h0000_0000, "edge_trap_clear");

        // Line held high through reset must not look like an edge
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        applyStimulus();
        readB(12'h344, 32'h0000_0000, "held_through_reset_1");
        applyStimulus();
        readB(12'h344, 32'h0000_0000, "held_through_reset_2");
        intrExt = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
